// File: rtl/timer_irq_ctrl_if.sv
// Register/event port of timer_irq_ctrl: timer inputs, register read/write strobes,
// registered read data and the CPU interrupt line.
interface timer_irq_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [CNT_W-1:0] count;
  logic             tmr_irq;
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [CNT_W-1:0] wr_data;
  logic             rd_en;
  logic [1:0]       rd_addr;
  logic [CNT_W-1:0] rd_data;
  logic             rd_valid;
  logic             irq_out;

  modport master (
    output count, tmr_irq, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    input  rd_data, rd_valid, irq_out
  );

  modport slave (
    input  count, tmr_irq, wr_en, wr_addr, wr_data, rd_en, rd_addr,
    output rd_data, rd_valid, irq_out
  );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt controller: edge-detects timer and compare events into W1C pending
// bits, counts missed events, snapshots the count and drives one maskable irq line.
module timer_irq_ctrl #(
  parameter int CNT_W  = 16,
  parameter int MISS_W = 8
) (
  input logic            clk,
  input logic            reset,
  timer_irq_ctrl_if.slave bus
);

  localparam logic [1:0]        A_CTRL   = 2'd0;
  localparam logic [1:0]        A_STAT   = 2'd1;
  localparam logic [1:0]        A_CMP    = 2'd2;
  localparam logic [1:0]        A_SNAP   = 2'd3;
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  // CTRL bits: [0] tmr_ie, [1] cmp_en, [2] cmp_ie
  logic [2:0]        ctrl_q,     ctrl_d;
  logic              tmr_pend_q, tmr_pend_d;
  logic              cmp_pend_q, cmp_pend_d;
  logic [MISS_W-1:0] miss_q,     miss_d;
  logic [CNT_W-1:0]  cmp_q,      cmp_d;
  logic [CNT_W-1:0]  snap_q,     snap_d;
  logic              tmr_irq_d_q;
  logic              match_d_q;
  logic [CNT_W-1:0]  rd_data_q,  rd_data_d;
  logic              rd_valid_q;
  logic              irq_q,      irq_d;

  logic              tmr_ev, cmp_ev, match;
  logic              wr_ctrl, wr_stat, wr_cmp;
  logic              clr_t, clr_c, clr_m;
  logic              tmr_miss, cmp_miss;
  logic [1:0]        miss_inc;
  logic [MISS_W:0]   miss_sum;
  logic [CNT_W-1:0]  stat_val;

  // Event detection
  always_comb begin
    tmr_ev = bus.tmr_irq & ~tmr_irq_d_q;
    match  = ctrl_q[1] & (bus.count == cmp_q);
    cmp_ev = match & ~match_d_q;
  end

  // Write decode and W1C strobes
  always_comb begin
    wr_ctrl = bus.wr_en & (bus.wr_addr == A_CTRL);
    wr_stat = bus.wr_en & (bus.wr_addr == A_STAT);
    wr_cmp  = bus.wr_en & (bus.wr_addr == A_CMP);
    clr_t   = wr_stat & bus.wr_data[0];
    clr_c   = wr_stat & bus.wr_data[1];
    clr_m   = wr_stat & bus.wr_data[2];
  end

  // A new event wins over a same-cycle clear and is then not a miss.
  always_comb begin
    tmr_miss = tmr_ev & tmr_pend_q & ~clr_t;
    cmp_miss = cmp_ev & cmp_pend_q & ~clr_c;
    miss_inc = {1'b0, tmr_miss} + {1'b0, cmp_miss};
    miss_sum = {1'b0, miss_q} + {{(MISS_W-1){1'b0}}, miss_inc};
    if (clr_m)
      miss_d = '0;
    else if (miss_sum > {1'b0, MISS_MAX})
      miss_d = MISS_MAX;
    else
      miss_d = miss_sum[MISS_W-1:0];
  end

  always_comb begin
    tmr_pend_d = tmr_pend_q;
    cmp_pend_d = cmp_pend_q;
    if (tmr_ev)     tmr_pend_d = 1'b1;
    else if (clr_t) tmr_pend_d = 1'b0;
    if (cmp_ev)     cmp_pend_d = 1'b1;
    else if (clr_c) cmp_pend_d = 1'b0;
  end

  always_comb begin
    ctrl_d = ctrl_q;
    cmp_d  = cmp_q;
    snap_d = snap_q;
    if (wr_ctrl) ctrl_d = bus.wr_data[2:0];
    if (wr_cmp)  cmp_d  = bus.wr_data;
    if (tmr_ev)  snap_d = bus.count;
  end

  // irq follows registered pend/ie, so it trails the pend update by one clock.
  always_comb begin
    irq_d = (tmr_pend_q & ctrl_q[0]) | (cmp_pend_q & ctrl_q[2]);
  end

  // Read mux sees pre-write state; rd_data holds when idle.
  always_comb begin
    stat_val              = '0;
    stat_val[0]           = tmr_pend_q;
    stat_val[1]           = cmp_pend_q;
    stat_val[MISS_W+1:2]  = miss_q;
    rd_data_d             = rd_data_q;
    if (bus.rd_en) begin
      case (bus.rd_addr)
        A_CTRL:  rd_data_d = {{(CNT_W-3){1'b0}}, ctrl_q};
        A_STAT:  rd_data_d = stat_val;
        A_CMP:   rd_data_d = cmp_q;
        A_SNAP:  rd_data_d = snap_q;
        default: rd_data_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q      <= '0;
      tmr_pend_q  <= 1'b0;
      cmp_pend_q  <= 1'b0;
      miss_q      <= '0;
      cmp_q       <= '0;
      snap_q      <= '0;
      tmr_irq_d_q <= 1'b0;
      match_d_q   <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ctrl_q      <= ctrl_d;
      tmr_pend_q  <= tmr_pend_d;
      cmp_pend_q  <= cmp_pend_d;
      miss_q      <= miss_d;
      cmp_q       <= cmp_d;
      snap_q      <= snap_d;
      tmr_irq_d_q <= bus.tmr_irq;
      match_d_q   <= match;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= bus.rd_en;
      irq_q       <= irq_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.irq_out  = irq_q;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: directed vector table, hand sequences for corner cases,
// then randomized traffic against an integer reference model.
module tb_timer_irq_ctrl;

  logic clk = 1'b0;
  logic reset;

  timer_irq_ctrl_if #(.CNT_W(16)) bus();

  timer_irq_ctrl #(.CNT_W(16), .MISS_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_ctrl, m_cmp, m_snap, m_tp, m_cp, m_miss;
  int m_prev_irq, m_prev_match, m_irq, m_rv, m_rd;

  typedef struct {
    logic        tmr;
    logic [15:0] cnt;
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic        re;
    logic [1:0]  ra;
    logic        e_irq;
    logic        e_rv;
    logic [15:0] e_rd;
  } vec_t;

  vec_t tbl [18];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int reg_val(input int a);
    case (a)
      0:       return m_ctrl;
      1:       return m_tp + 2 * m_cp + 4 * m_miss;
      2:       return m_cmp;
      default: return m_snap;
    endcase
  endfunction

  task automatic model_cycle();
    int evt, evc, mt, inc, clr_t, clr_c, clr_m, wd;
    if (reset) begin
      m_ctrl = 0; m_cmp = 0; m_snap = 0; m_tp = 0; m_cp = 0; m_miss = 0;
      m_prev_irq = 0; m_prev_match = 0; m_irq = 0; m_rv = 0; m_rd = 0;
      return;
    end
    wd  = int'(bus.wr_data);
    mt  = ((m_ctrl & 2) != 0 && int'(bus.count) == m_cmp) ? 1 : 0;
    evt = (bus.tmr_irq && m_prev_irq == 0) ? 1 : 0;
    evc = (mt == 1 && m_prev_match == 0) ? 1 : 0;
    if (bus.rd_en) m_rd = reg_val(int'(bus.rd_addr));
    m_rv  = bus.rd_en ? 1 : 0;
    m_irq = ((m_tp == 1 && (m_ctrl & 1) != 0) || (m_cp == 1 && (m_ctrl & 4) != 0)) ? 1 : 0;
    clr_t = (bus.wr_en && bus.wr_addr == 2'd1 && (wd & 1) != 0) ? 1 : 0;
    clr_c = (bus.wr_en && bus.wr_addr == 2'd1 && (wd & 2) != 0) ? 1 : 0;
    clr_m = (bus.wr_en && bus.wr_addr == 2'd1 && (wd & 4) != 0) ? 1 : 0;
    inc = 0;
    if (evt == 1 && m_tp == 1 && clr_t == 0) inc++;
    if (evc == 1 && m_cp == 1 && clr_c == 0) inc++;
    if (clr_m == 1)           m_miss = 0;
    else if (m_miss + inc > 255) m_miss = 255;
    else                      m_miss = m_miss + inc;
    if (evt == 1) begin m_tp = 1; m_snap = int'(bus.count); end
    else if (clr_t == 1) m_tp = 0;
    if (evc == 1) m_cp = 1;
    else if (clr_c == 1) m_cp = 0;
    if (bus.wr_en && bus.wr_addr == 2'd0) m_ctrl = wd & 7;
    if (bus.wr_en && bus.wr_addr == 2'd2) m_cmp = wd;
    m_prev_irq   = bus.tmr_irq ? 1 : 0;
    m_prev_match = mt;
  endtask

  task automatic step();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    bus.wr_en = 1'b1; bus.wr_addr = a; bus.wr_data = d;
  endtask

  task automatic rd(input logic [1:0] a);
    bus.rd_en = 1'b1; bus.rd_addr = a;
  endtask

  task automatic do_reset();
    idle(); reset = 1'b1; step(); reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bus.tmr_irq = 1'b0; bus.count = '0;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.rd_en = 1'b0; bus.rd_addr = '0;
    step(); step();
    check("reset irq_out", 32'(bus.irq_out), 32'd0);
    check("reset rd_valid", 32'(bus.rd_valid), 32'd0);
    check("reset rd_data", 32'(bus.rd_data), 32'd0);
    reset = 1'b0;

    //        tmr   cnt     we    wa    wd      re    ra    irq   rv    rd
    tbl[0]  = '{1'b0, 16'd0, 1'b1, 2'd0, 16'd1, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 16'd0, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd1, 1'b1, 1'b1, 16'd1};
    tbl[3]  = '{1'b0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd3, 1'b1, 1'b1, 16'd0};
    tbl[4]  = '{1'b0, 16'd0, 1'b1, 2'd1, 16'd1, 1'b1, 2'd1, 1'b1, 1'b1, 16'd1};
    tbl[5]  = '{1'b0, 16'd0, 1'b0, 2'd0, 16'd0, 1'b1, 2'd1, 1'b0, 1'b1, 16'd0};
    tbl[6]  = '{1'b0, 16'd0, 1'b1, 2'd2, 16'd5, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
    tbl[7]  = '{1'b0, 16'd0, 1'b1, 2'd0, 16'd6, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
    tbl[8]  = '{1'b0, 16'd7, 1'b0, 2'd0, 16'd0, 1'b1, 2'd2, 1'b0, 1'b1, 16'd5};
    tbl[9]  = '{1'b0, 16'd6, 1'b0, 2'd0, 16'd0, 1'b1, 2'd0, 1'b0, 1'b1, 16'd6};
    tbl[10] = '{1'b0, 16'd5, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd6};
    tbl[11] = '{1'b0, 16'd4, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd6};
    tbl[12] = '{1'b0, 16'd3, 1'b0, 2'd0, 16'd0, 1'b1, 2'd1, 1'b1, 1'b1, 16'd2};
    tbl[13] = '{1'b0, 16'd2, 1'b1, 2'd1, 16'd2, 1'b0, 2'd0, 1'b1, 1'b0, 16'd2};
    tbl[14] = '{1'b0, 16'd1, 1'b0, 2'd0, 16'd0, 1'b1, 2'd1, 1'b0, 1'b1, 16'd0};
    tbl[15] = '{1'b0, 16'd5, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd0};
    tbl[16] = '{1'b0, 16'd5, 1'b0, 2'd0, 16'd0, 1'b0, 2'd0, 1'b1, 1'b0, 16'd0};
    tbl[17] = '{1'b0, 16'd5, 1'b0, 2'd0, 16'd0, 1'b1, 2'd1, 1'b1, 1'b1, 16'd2};

    for (int i = 0; i < 18; i++) begin
      bus.tmr_irq = tbl[i].tmr;  bus.count   = tbl[i].cnt;
      bus.wr_en   = tbl[i].we;   bus.wr_addr = tbl[i].wa;  bus.wr_data = tbl[i].wd;
      bus.rd_en   = tbl[i].re;   bus.rd_addr = tbl[i].ra;
      step();
      check($sformatf("vec%0d irq_out", i), 32'(bus.irq_out), 32'(tbl[i].e_irq));
      check($sformatf("vec%0d rd_valid", i), 32'(bus.rd_valid), 32'(tbl[i].e_rv));
      check($sformatf("vec%0d rd_data", i), 32'(bus.rd_data), 32'(tbl[i].e_rd));
    end
    idle(); bus.count = 16'hFFFF;

    // Held level with interrupt masked, then unmask
    do_reset();
    bus.tmr_irq = 1'b1;
    repeat (10) step();
    rd(2'd1); step(); idle();
    check("held stat", 32'(bus.rd_data), 32'h1);
    check("held irq masked", 32'(bus.irq_out), 32'd0);
    bus.tmr_irq = 1'b0; wr(2'd0, 16'd1); step(); idle();
    check("unmask irq edge", 32'(bus.irq_out), 32'd0);
    step();
    check("unmask irq next", 32'(bus.irq_out), 32'd1);

    // Miss counter saturation and clear
    do_reset();
    for (int i = 0; i < 300; i++) begin
      bus.tmr_irq = 1'b1; step();
      bus.tmr_irq = 1'b0; step();
    end
    rd(2'd1); step(); idle();
    check("miss saturated", 32'(bus.rd_data), 32'h3FD);
    wr(2'd1, 16'd4); step(); idle();
    rd(2'd1); step(); idle();
    check("miss cleared", 32'(bus.rd_data), 32'h001);

    // Event vs W1C of the same bit, then miss vs miss-clear
    bus.tmr_irq = 1'b1; wr(2'd1, 16'd1); step(); idle();
    bus.tmr_irq = 1'b0; rd(2'd1); step(); idle();
    check("event beats w1c", 32'(bus.rd_data), 32'h001);
    bus.tmr_irq = 1'b1; step();
    bus.tmr_irq = 1'b0; rd(2'd1); step(); idle();
    check("plain miss", 32'(bus.rd_data), 32'h005);
    bus.tmr_irq = 1'b1; wr(2'd1, 16'd4); step(); idle();
    bus.tmr_irq = 1'b0; rd(2'd1); step(); idle();
    check("miss clear wins", 32'(bus.rd_data), 32'h001);

    // Reset mid-operation with irq active; tmr_irq high across release
    wr(2'd0, 16'd1); step(); idle(); step();
    check("pre-reset irq", 32'(bus.irq_out), 32'd1);
    bus.tmr_irq = 1'b1; rd(2'd1); reset = 1'b1; step(); reset = 1'b0; idle();
    check("mid reset irq", 32'(bus.irq_out), 32'd0);
    check("mid reset rd_valid", 32'(bus.rd_valid), 32'd0);
    check("mid reset rd_data", 32'(bus.rd_data), 32'd0);
    rd(2'd0); step(); idle();
    check("post reset ctrl", 32'(bus.rd_data), 32'd0);
    rd(2'd1); step(); idle();
    check("release event", 32'(bus.rd_data), 32'h001);
    bus.tmr_irq = 1'b0;

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 499) == 0);
      bus.tmr_irq  = ($urandom_range(0, 2) == 0);
      bus.count    = 16'($urandom_range(0, 7));
      bus.wr_en    = ($urandom_range(0, 7) == 0);
      bus.wr_addr  = 2'($urandom_range(0, 3));
      bus.wr_data  = (bus.wr_addr == 2'd2) ? 16'($urandom_range(0, 7)) : 16'($urandom);
      bus.rd_en    = $urandom_range(0, 1) == 1;
      bus.rd_addr  = 2'($urandom_range(0, 3));
      step();
      check($sformatf("rand%0d irq_out", i), 32'(bus.irq_out), 32'(m_irq));
      check($sformatf("rand%0d rd_valid", i), 32'(bus.rd_valid), 32'(m_rv));
      check($sformatf("rand%0d rd_data", i), 32'(bus.rd_data), 32'(m_rd));
    end
    reset = 1'b0; idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
